// File: rtl/conv1d_engine_if.sv
// SRAM port between the conv1d engine (master) and the single-port array (slave).
// rdata is valid the cycle after a read request.
interface conv1d_engine_if #(
    parameter int AW = 7,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;

    modport master (output req, we, addr, wdata, input rdata);
    modport slave  (input req, we, addr, wdata, output rdata);
endinterface

// File: rtl/conv1d_engine.sv
// Valid-mode 1-D cross-correlation y[i] = sum_j x[i+j]*k[j] over a shared SRAM.
// Kernel is cached in registers; each output is accumulated and written back.
module conv1d_engine #(
    parameter int KMAX = 8,
    parameter int AW   = 7,
    parameter int DW   = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [AW-1:0]          in_base_i,
    input  logic [AW-1:0]          in_len_i,
    input  logic [AW-1:0]          k_base_i,
    input  logic [3:0]             k_len_i,
    input  logic [AW-1:0]          out_base_i,
    conv1d_engine_if.master        mem,
    output logic                   ext_gnt_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   done_evt_o,
    output logic                   err_o
);
    localparam int KW = $clog2(KMAX);

    typedef enum logic [1:0] {IDLE, LOAD_K, MAC, WRITE} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [AW-1:0]           idx_q, idx_d;
    logic [AW-1:0]           in_base_q, in_base_d, in_len_q, in_len_d;
    logic [AW-1:0]           k_base_q, k_base_d, out_base_q, out_base_d;
    logic [3:0]              k_len_q, k_len_d;
    logic [KMAX-1:0][DW-1:0] kreg_q, kreg_d;
    logic [DW-1:0]           acc_q, acc_d;
    logic                    cap_vld_q, cap_vld_d, cap_mac_q, cap_mac_d;
    logic [KW-1:0]           cap_tap_q, cap_tap_d;
    logic                    req_q, req_d, we_q, we_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [DW-1:0]           wdata_q, wdata_d;
    logic                    busy_q, busy_d, gnt_q, gnt_d;
    logic                    done_q, done_d, evt_q, evt_d, err_q, err_d;
    logic                    cfg_bad;

    assign cfg_bad = (k_len_i == 4'd0) || (k_len_i > 4'(KMAX)) ||
                     (in_len_i == '0) || (AW'(k_len_i) > in_len_i);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        in_base_d  = in_base_q;
        in_len_d   = in_len_q;
        k_base_d   = k_base_q;
        k_len_d    = k_len_q;
        out_base_d = out_base_q;
        kreg_d     = kreg_q;
        acc_d      = acc_q;
        done_d     = done_q;
        err_d      = err_q;
        evt_d      = 1'b0;
        // Remember which tap the read issued this cycle belongs to; data lands next cycle.
        cap_vld_d  = req_q && !we_q;
        cap_mac_d  = (state_q == MAC);
        cap_tap_d  = cnt_q[KW-1:0];

        if (cap_vld_q) begin
            if (cap_mac_q) acc_d = acc_q + mem.rdata * kreg_q[cap_tap_q];
            else           kreg_d[cap_tap_q] = mem.rdata;
        end

        case (state_q)
            IDLE: if (start_i) begin
                in_base_d  = in_base_i;
                in_len_d   = in_len_i;
                k_base_d   = k_base_i;
                k_len_d    = k_len_i;
                out_base_d = out_base_i;
                cnt_d      = '0;
                idx_d      = '0;
                done_d     = 1'b0;
                err_d      = 1'b0;
                if (cfg_bad) begin
                    err_d  = 1'b1;
                    done_d = 1'b1;
                    evt_d  = 1'b1;
                end else begin
                    state_d = LOAD_K;
                end
            end
            LOAD_K: begin
                if (cnt_q == k_len_q) begin
                    state_d = MAC;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 4'd1;
            end
            MAC: begin
                if (cnt_q == 4'd0) acc_d = '0;
                if (cnt_q == k_len_q) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 4'd1;
            end
            WRITE: begin
                if (idx_q == in_len_q - AW'(k_len_q)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    evt_d   = 1'b1;
                end else begin
                    state_d = MAC;
                    idx_d   = idx_q + AW'(1);
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Bus outputs are registered: derive them from the state entered next.
        req_d   = 1'b0;
        we_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        case (state_d)
            LOAD_K: if (cnt_d < k_len_d) begin
                req_d  = 1'b1;
                addr_d = k_base_d + AW'(cnt_d);
            end
            MAC: if (cnt_d < k_len_d) begin
                req_d  = 1'b1;
                addr_d = in_base_d + idx_d + AW'(cnt_d);
            end
            WRITE: begin
                req_d   = 1'b1;
                we_d    = 1'b1;
                addr_d  = out_base_d + idx_d;
                wdata_d = acc_d;
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
        gnt_d  = !busy_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            in_base_q  <= '0;
            in_len_q   <= '0;
            k_base_q   <= '0;
            k_len_q    <= '0;
            out_base_q <= '0;
            kreg_q     <= '0;
            acc_q      <= '0;
            cap_vld_q  <= 1'b0;
            cap_mac_q  <= 1'b0;
            cap_tap_q  <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            gnt_q      <= 1'b1;
            done_q     <= 1'b0;
            evt_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            in_base_q  <= in_base_d;
            in_len_q   <= in_len_d;
            k_base_q   <= k_base_d;
            k_len_q    <= k_len_d;
            out_base_q <= out_base_d;
            kreg_q     <= kreg_d;
            acc_q      <= acc_d;
            cap_vld_q  <= cap_vld_d;
            cap_mac_q  <= cap_mac_d;
            cap_tap_q  <= cap_tap_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            evt_q      <= evt_d;
            err_q      <= err_d;
        end
    end

    assign mem.req     = req_q;
    assign mem.we      = we_q;
    assign mem.addr    = addr_q;
    assign mem.wdata   = wdata_q;
    assign ext_gnt_o   = gnt_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign done_evt_o  = evt_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_conv1d_engine.sv
// Directed bench for conv1d_engine: table of configurations with hand-computed
// results against an SRAM model, plus read-order, interference and back-to-back sequences.
module tb_conv1d_engine;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [6:0]  in_base_i = '0, in_len_i = '0, k_base_i = '0, out_base_i = '0;
    logic [3:0]  k_len_i = '0;
    logic        ext_gnt_o, busy_o, done_o, done_evt_o, err_o;

    always #5 clk_i = ~clk_i;

    conv1d_engine_if #(.AW(7), .DW(32)) bus ();

    conv1d_engine #(.KMAX(8), .AW(7), .DW(32)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .in_base_i  (in_base_i),
        .in_len_i   (in_len_i),
        .k_base_i   (k_base_i),
        .k_len_i    (k_len_i),
        .out_base_i (out_base_i),
        .mem        (bus),
        .ext_gnt_o  (ext_gnt_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .done_evt_o (done_evt_o),
        .err_o      (err_o)
    );

    // SRAM model: engine owns the port while ext_gnt_o is low, host otherwise.
    logic [31:0] sram [128];
    logic [31:0] rdata_q = '0;
    logic        host_we = 1'b0;
    logic [6:0]  host_addr = '0;
    logic [31:0] host_wdata = '0;
    int          busy_cnt = 0, evt_cnt = 0, req_cnt = 0, wr_cnt = 0, gnt_bad = 0;
    logic [6:0]  rd_log [$];

    assign bus.rdata = rdata_q;

    always @(posedge clk_i) begin
        if (bus.req) begin
            if (bus.we) sram[bus.addr] <= bus.wdata;
            else begin
                rdata_q <= sram[bus.addr];
                rd_log.push_back(bus.addr);
            end
        end else if (host_we && ext_gnt_o) sram[host_addr] <= host_wdata;
        if (busy_o)              busy_cnt <= busy_cnt + 1;
        if (done_evt_o)          evt_cnt  <= evt_cnt + 1;
        if (bus.req)             req_cnt  <= req_cnt + 1;
        if (bus.req && bus.we)   wr_cnt   <= wr_cnt + 1;
        if ((ext_gnt_o == busy_o) || (bus.req && ext_gnt_o)) gnt_bad <= gnt_bad + 1;
    end

    int total = 0, bad = 0;
    int s_busy, s_evt, s_req, s_wr, s_gnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic host_wr(input logic [6:0] a, input logic [31:0] d);
        @(negedge clk_i);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        @(negedge clk_i);
        host_we = 1'b0;
    endtask

    task automatic start_cfg(input logic [6:0] inb, len, kb, input logic [3:0] k, input logic [6:0] ob);
        @(negedge clk_i);
        in_base_i = inb; in_len_i = len; k_base_i = kb; k_len_i = k; out_base_i = ob;
        start_i = 1'b1;
        s_busy = busy_cnt; s_evt = evt_cnt; s_req = req_cnt; s_wr = wr_cnt; s_gnt = gnt_bad;
        rd_log.delete();
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_evt(input string nm);
        int n = 0;
        while (!done_evt_o && n < 1000) begin
            @(negedge clk_i);
            n++;
        end
        if (!done_evt_o) begin
            total++; bad++;
            $display("FAIL %s timeout: got no done_evt_o expected pulse within 1000 cycles", nm);
        end
    endtask

    typedef struct {
        logic [6:0]        inb, len, kb;
        logic [3:0]        k;
        logic [6:0]        ob;
        logic [7:0][31:0]  x, kv, y;
        bit                err;
        int                busy;
    } vec_t;

    function automatic logic [7:0][31:0] w8(input int a0 = 0, a1 = 0, a2 = 0, a3 = 0,
                                            a4 = 0, a5 = 0, a6 = 0, a7 = 0);
        w8[0] = a0; w8[1] = a1; w8[2] = a2; w8[3] = a3;
        w8[4] = a4; w8[5] = a5; w8[6] = a6; w8[7] = a7;
    endfunction

    function automatic vec_t mk(input logic [6:0] inb, len, kb, input logic [3:0] k,
                                input logic [6:0] ob, input logic [7:0][31:0] x, kv, y,
                                input bit err, input int busy);
        mk.inb = inb; mk.len = len; mk.kb = kb; mk.k = k; mk.ob = ob;
        mk.x = x; mk.kv = kv; mk.y = y; mk.err = err; mk.busy = busy;
    endfunction

    localparam int NV = 9;
    vec_t tv [NV];

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = mk(0, 8, 64, 3, 96, w8(1,2,3,4,5,6,7,8), w8(1,0,-1),
                   w8(-2,-2,-2,-2,-2,-2), 0, 34);
        tv[1] = mk(0, 4, 64, 1, 96, w8(1,2,3,4), w8(5), w8(5,10,15,20), 0, 14);
        tv[2] = mk(0, 4, 64, 0, 96, w8(1,2,3,4), w8(), w8(), 1, 0);
        tv[3] = mk(0, 10, 64, 9, 96, w8(1,2,3,4,5,6,7,8), w8(1,1,1,1,1,1,1,1), w8(), 1, 0);
        tv[4] = mk(0, 4, 64, 5, 96, w8(1,2,3,4), w8(1,1,1,1,1), w8(), 1, 0);
        tv[5] = mk(0, 1, 64, 1, 96, w8(32'h7FFFFFFF), w8(2), w8(32'hFFFFFFFE), 0, 5);
        tv[6] = mk(0, 8, 64, 8, 96, w8(1,2,3,4,5,6,7,8), w8(1,1,1,1,1,1,1,1), w8(36), 0, 19);
        tv[7] = mk(0, 3, 64, 2, 96, w8(2,-1,4), w8(-3,7), w8(-13,31), 0, 11);
        tv[8] = mk(126, 4, 64, 2, 96, w8(3,4,5,6), w8(1,2), w8(11,14,17), 0, 15);

        repeat (3) @(negedge clk_i);
        chk("rst req", bus.req, 0);
        chk("rst we", bus.we, 0);
        chk("rst addr", bus.addr, 0);
        chk("rst wdata", bus.wdata, 0);
        chk("rst busy", busy_o, 0);
        chk("rst gnt", ext_gnt_o, 1);
        chk("rst done", done_o, 0);
        chk("rst evt", done_evt_o, 0);
        chk("rst err", err_o, 0);
        rst_i = 1'b0;

        for (int v = 0; v < NV; v++) begin
            for (int j = 0; j < int'(tv[v].len) && j < 8; j++)
                host_wr(tv[v].inb + 7'(j), tv[v].x[j]);
            for (int j = 0; j < int'(tv[v].k) && j < 8; j++)
                host_wr(tv[v].kb + 7'(j), tv[v].kv[j]);
            start_cfg(tv[v].inb, tv[v].len, tv[v].kb, tv[v].k, tv[v].ob);
            wait_evt($sformatf("vec%0d", v));
            repeat (2) @(negedge clk_i);
            chk($sformatf("vec%0d err", v), err_o, tv[v].err);
            chk($sformatf("vec%0d done", v), done_o, 1);
            chk($sformatf("vec%0d evt pulses", v), evt_cnt - s_evt, 1);
            chk($sformatf("vec%0d busy cycles", v), busy_cnt - s_busy, tv[v].busy);
            chk($sformatf("vec%0d gnt overlap", v), gnt_bad - s_gnt, 0);
            chk($sformatf("vec%0d idle gnt", v), ext_gnt_o, 1);
            if (tv[v].err) chk($sformatf("vec%0d req count", v), req_cnt - s_req, 0);
            else begin
                chk($sformatf("vec%0d writes", v), wr_cnt - s_wr,
                    int'(tv[v].len) - int'(tv[v].k) + 1);
                for (int i = 0; i < int'(tv[v].len) - int'(tv[v].k) + 1; i++)
                    chk($sformatf("vec%0d y%0d", v, i), sram[tv[v].ob + 7'(i)], tv[v].y[i]);
            end
        end

        // Last vector starts its input window at 126: reads must wrap to 0.
        begin
            logic [6:0] exp_rd [8];
            exp_rd = '{7'd64, 7'd65, 7'd126, 7'd127, 7'd127, 7'd0, 7'd0, 7'd1};
            chk("wrap read count", rd_log.size(), 8);
            for (int i = 0; i < 8 && i < rd_log.size(); i++)
                chk($sformatf("wrap read %0d", i), rd_log[i], exp_rd[i]);
        end

        // Stray start at cycle 5 and reset at cycle 20 of the basic run.
        for (int j = 0; j < 8; j++) host_wr(7'(j), 32'(j + 1));
        host_wr(64, 1); host_wr(65, 0); host_wr(66, 32'hFFFFFFFF);
        for (int j = 96; j < 104; j++) host_wr(7'(j), 32'hAAAAAAAA);
        host_wr(110, 32'hAAAAAAAA);
        start_cfg(0, 8, 64, 3, 96);
        repeat (5) @(negedge clk_i);
        in_base_i = 0; in_len_i = 4; k_base_i = 64; k_len_i = 1; out_base_i = 110;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (14) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("abort busy", busy_o, 0);
        chk("abort gnt", ext_gnt_o, 1);
        chk("abort req", bus.req, 0);
        chk("abort done", done_o, 0);
        chk("abort err", err_o, 0);
        chk("abort evt", done_evt_o, 0);
        repeat (10) @(negedge clk_i);
        chk("abort writes", wr_cnt - s_wr, 3);
        chk("abort evt pulses", evt_cnt - s_evt, 0);
        for (int i = 0; i < 3; i++) chk($sformatf("abort y%0d", i), sram[96 + i], 32'hFFFFFFFE);
        chk("abort no y3", sram[99], 32'hAAAAAAAA);
        chk("abort stray start", sram[110], 32'hAAAAAAAA);

        // Back-to-back: second start lands in the done_evt_o cycle.
        for (int j = 0; j < 4; j++) host_wr(7'(j), 32'(j + 1));
        host_wr(64, 5); host_wr(65, 3);
        start_cfg(0, 4, 64, 1, 96);
        wait_evt("b2b first");
        in_base_i = 2; in_len_i = 2; k_base_i = 65; k_len_i = 1; out_base_i = 110;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("b2b done cleared", done_o, 0);
        chk("b2b busy", busy_o, 1);
        wait_evt("b2b second");
        repeat (2) @(negedge clk_i);
        chk("b2b done", done_o, 1);
        chk("b2b evt pulses", evt_cnt - s_evt, 2);
        for (int i = 0; i < 4; i++) chk($sformatf("b2b first y%0d", i), sram[96 + i], 32'(5 * (i + 1)));
        chk("b2b second y0", sram[110], 9);
        chk("b2b second y1", sram[111], 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
